// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Zero-latency lookup for fetch and a single synchronous update port from execute.
module branch_target_predictor #(
  parameter int DBITS      = 32,
  parameter int INSTSIZE   = 4,
  parameter int BTBIDXBITS = 6,
  parameter int TAGBITS    = DBITS - BTBIDXBITS - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] pc_fe,
  output logic [DBITS-1:0] pred_pc,
  output logic             pred_taken,
  input  logic             upd_en,
  input  logic [DBITS-1:0] upd_pc,
  input  logic             upd_is_jmp,
  input  logic             upd_taken,
  input  logic [DBITS-1:0] upd_target,
  input  logic             upd_mispred,
  output logic [DBITS-1:0] br_cnt,
  output logic [DBITS-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << BTBIDXBITS;

  logic [ENTRIES-1:0] valid_tab;
  logic [ENTRIES-1:0] jmp_tab;
  logic [1:0]         ctr_tab    [ENTRIES];
  logic [TAGBITS-1:0] tag_tab    [ENTRIES];
  logic [DBITS-1:0]   target_tab [ENTRIES];

  logic [BTBIDXBITS-1:0] fe_idx;
  logic [TAGBITS-1:0]    fe_tag;
  logic                  fe_hit;

  logic [BTBIDXBITS-1:0] upd_idx;
  logic [TAGBITS-1:0]    upd_tag;
  logic                  upd_hit;
  logic                  upd_alloc;
  logic                  upd_write_target;
  logic [1:0]            next_ctr;
  logic                  next_jmp;
  logic                  unused_low_bits;

  assign unused_low_bits = ^upd_pc[1:0];

  assign fe_idx = pc_fe[BTBIDXBITS+1:2];
  assign fe_tag = pc_fe[DBITS-1:BTBIDXBITS+2];

  always_comb begin
    fe_hit     = valid_tab[fe_idx] && (tag_tab[fe_idx] == fe_tag);
    pred_taken = fe_hit && (jmp_tab[fe_idx] || ctr_tab[fe_idx][1]);
    pred_pc    = pred_taken ? target_tab[fe_idx] : pc_fe + DBITS'(INSTSIZE);
  end

  assign upd_idx = upd_pc[BTBIDXBITS+1:2];
  assign upd_tag = upd_pc[DBITS-1:BTBIDXBITS+2];

  // A miss only claims the slot for transfers that were actually taken.
  always_comb begin
    upd_hit          = valid_tab[upd_idx] && (tag_tab[upd_idx] == upd_tag);
    upd_alloc        = !upd_hit && (upd_taken || upd_is_jmp);
    upd_write_target = upd_en && (upd_alloc || (upd_hit && (upd_is_jmp || upd_taken)));
    next_ctr         = ctr_tab[upd_idx];
    next_jmp         = jmp_tab[upd_idx];
    if (upd_hit) begin
      if (upd_is_jmp) begin
        next_ctr = 2'b11;
        next_jmp = 1'b1;
      end else if (upd_taken) begin
        next_ctr = (ctr_tab[upd_idx] == 2'b11) ? 2'b11 : ctr_tab[upd_idx] + 2'b01;
        next_jmp = 1'b0;
      end else begin
        next_ctr = (ctr_tab[upd_idx] == 2'b00) ? 2'b00 : ctr_tab[upd_idx] - 2'b01;
      end
    end else if (upd_alloc) begin
      next_ctr = upd_is_jmp ? 2'b11 : 2'b10;
      next_jmp = upd_is_jmp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_tab   <= '0;
      jmp_tab     <= '0;
      br_cnt      <= '0;
      mispred_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_tab[i] <= 2'b01;
      end
    end else if (upd_en) begin
      ctr_tab[upd_idx]   <= next_ctr;
      jmp_tab[upd_idx]   <= next_jmp;
      valid_tab[upd_idx] <= valid_tab[upd_idx] | upd_alloc;
      if (br_cnt != '1) begin
        br_cnt <= br_cnt + DBITS'(1);
      end
      if (upd_mispred && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + DBITS'(1);
      end
    end
  end

  // Tags and targets carry no reset; validity alone guards them.
  always_ff @(posedge clk) begin
    if (upd_write_target && !reset) begin
      tag_tab[upd_idx]    <= upd_tag;
      target_tab[upd_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: fixed vector table, corner-case sequences and random
// traffic compared against a table model built from the prediction rules.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_fe;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_is_jmp;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int vectors = 0;
  int miscompares = 0;

  branch_target_predictor dut (
    .clk(clk), .reset(reset), .pc_fe(pc_fe), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_is_jmp(upd_is_jmp), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: 64 entries indexed by word address, tag is the rest.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  bit          m_jmp    [64];
  longint unsigned m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / 256;
  endfunction

  function void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
      m_jmp[i]   = 0;
    end
    m_br  = 0;
    m_mis = 0;
  endfunction

  function void model_predict(input logic [31:0] pc, output bit t, output logic [31:0] npc);
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    t   = hit && (m_jmp[i] || m_ctr[i] >= 2);
    npc = t ? m_target[i] : pc + 32'd4;
  endfunction

  function void model_update(input logic [31:0] pc, input bit jmp, input bit taken,
                             input logic [31:0] tgt, input bit mis);
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (hit) begin
      if (jmp) begin
        m_ctr[i] = 3; m_jmp[i] = 1; m_target[i] = tgt;
      end else if (taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_jmp[i] = 0; m_target[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (taken || jmp) begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt;
      m_jmp[i] = jmp; m_ctr[i] = jmp ? 3 : 2;
    end
    if (m_br < 64'hFFFF_FFFF) m_br++;
    if (mis && m_mis < 64'hFFFF_FFFF) m_mis++;
  endfunction

  function void check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  task apply_stimulus(input bit en, input logic [31:0] pc, input bit jmp, input bit taken,
                      input logic [31:0] tgt, input bit mis);
    upd_en = en; upd_pc = pc; upd_is_jmp = jmp; upd_taken = taken;
    upd_target = tgt; upd_mispred = mis;
  endtask

  // Clock edge with model tracking; returns at edge+1 with the update port idle.
  task clock_edge();
    @(posedge clk);
    if (upd_en && !reset) model_update(upd_pc, upd_is_jmp, upd_taken, upd_target, upd_mispred);
    #1;
    apply_stimulus(0, 0, 0, 0, 0, 0);
  endtask

  task check_model(input string name);
    bit          t;
    logic [31:0] npc;
    model_predict(pc_fe, t, npc);
    check_output({name, "_taken"}, 32'(pred_taken), 32'(t));
    check_output({name, "_pc"}, pred_pc, npc);
    check_output({name, "_br"}, br_cnt, m_br[31:0]);
    check_output({name, "_mis"}, mispred_cnt, m_mis[31:0]);
  endtask

  typedef struct {
    bit          en;
    logic [31:0] pc;
    bit          jmp;
    bit          taken;
    logic [31:0] tgt;
    bit          mis;
    logic [31:0] look;
    bit          exp_taken;
    logic [31:0] exp_pc;
    logic [31:0] exp_br;
    logic [31:0] exp_mis;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1, 32'h120, 0, 1, 32'h200, 1, 32'h120, 1, 32'h200, 1, 1};
    vecs[1]  = '{1, 32'h120, 0, 0, 32'h0,   1, 32'h120, 0, 32'h124, 2, 2};
    vecs[2]  = '{1, 32'h120, 0, 1, 32'h200, 1, 32'h120, 1, 32'h200, 3, 3};
    vecs[3]  = '{1, 32'h120, 0, 1, 32'h200, 0, 32'h120, 1, 32'h200, 4, 3};
    vecs[4]  = '{1, 32'h120, 0, 1, 32'h200, 0, 32'h120, 1, 32'h200, 5, 3};
    vecs[5]  = '{1, 32'h120, 0, 1, 32'h200, 0, 32'h120, 1, 32'h200, 6, 3};
    vecs[6]  = '{1, 32'h120, 0, 0, 32'h0,   0, 32'h120, 1, 32'h200, 7, 3};
    vecs[7]  = '{0, 32'h0,   0, 0, 32'h0,   1, 32'h220, 0, 32'h224, 7, 3};
    vecs[8]  = '{1, 32'h220, 0, 1, 32'h400, 1, 32'h220, 1, 32'h400, 8, 4};
    vecs[9]  = '{0, 32'h0,   0, 0, 32'h0,   0, 32'h120, 0, 32'h124, 8, 4};
    vecs[10] = '{0, 32'h0,   0, 0, 32'h0,   0, 32'h222, 1, 32'h400, 8, 4};
    vecs[11] = '{1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 0, 32'h0, 9, 4};
    vecs[12] = '{1, 32'h300, 0, 0, 32'h0,   1, 32'h300, 0, 32'h304, 10, 5};

    apply_stimulus(0, 0, 0, 0, 0, 0);
    pc_fe = 32'h100;
    reset = 1'b1;
    model_reset();
    #1;
    check_output("reset_taken", 32'(pred_taken), 32'd0);
    check_output("reset_pc", pred_pc, 32'h104);
    check_output("reset_br", br_cnt, 32'd0);
    check_output("reset_mis", mispred_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 13; v++) begin
      apply_stimulus(vecs[v].en, vecs[v].pc, vecs[v].jmp, vecs[v].taken, vecs[v].tgt, vecs[v].mis);
      pc_fe = vecs[v].look;
      clock_edge();
      check_output($sformatf("vec%0d_taken", v), 32'(pred_taken), 32'(vecs[v].exp_taken));
      check_output($sformatf("vec%0d_pc", v), pred_pc, vecs[v].exp_pc);
      check_output($sformatf("vec%0d_br", v), br_cnt, vecs[v].exp_br);
      check_output($sformatf("vec%0d_mis", v), mispred_cnt, vecs[v].exp_mis);
    end

    // Lookup in the update cycle sees the old table; new entry appears next cycle.
    pc_fe = 32'h140;
    apply_stimulus(1, 32'h140, 0, 1, 32'h300, 0);
    #1;
    check_output("same_cycle_before", pred_pc, 32'h144);
    clock_edge();
    check_output("same_cycle_after", pred_pc, 32'h300);

    apply_stimulus(1, 32'h160, 1, 1, 32'h500, 0);
    clock_edge();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 32'h160, 0, 0, 32'h0, 0);
      clock_edge();
    end
    pc_fe = 32'h160;
    #1;
    check_output("jal_sticky_taken", 32'(pred_taken), 32'd1);
    check_output("jal_sticky_pc", pred_pc, 32'h500);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      apply_stimulus($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
      pc_fe = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      #1;
      check_model($sformatf("rand%0d_pre", n));
      clock_edge();
      check_model($sformatf("rand%0d_post", n));
    end

    // Populate, then reset between edges and expect immediate clearing.
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1, 32'h180 + 32'(k * 4), 0, 1, 32'h700 + 32'(k * 16), k[0]);
      clock_edge();
    end
    pc_fe = 32'h180;
    #1;
    check_output("pre_reset_br", br_cnt, 32'd5);
    check_output("pre_reset_hit", pred_pc, 32'h700);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_output("async_reset_taken", 32'(pred_taken), 32'd0);
    check_output("async_reset_pc", pred_pc, 32'h184);
    check_output("async_reset_br", br_cnt, 32'd0);
    check_output("async_reset_mis", mispred_cnt, 32'd0);
    apply_stimulus(1, 32'h180, 0, 1, 32'h900, 1);
    clock_edge();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("post_reset_miss", pred_pc, 32'h184);
    check_output("post_reset_br", br_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
